// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into RISC-V I/S/B/J fields and
// queues the word with a byte address in a 2-entry FIFO. Optional check: IMM_CHECK_EN.
module imm_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] base_instr,
    input  logic [31:0] imm,
    input  logic [1:0]  immSrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        err_sticky,
    output logic [15:0] word_count
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    entry_t [1:0] mem_q, mem_d;
    entry_t       head_q, head_d;
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic [31:0]  addr_q, addr_d;
    logic [15:0]  word_count_q, word_count_d;
    logic         sticky_q, sticky_d;
    logic [31:0]  enc_word;
    logic         imm_err;
    logic         push, pop;
    logic         imm_unused;

    // High immediate bits only feed the optional range check.
    assign imm_unused = ^imm[31:21];

    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_instr  = head_q.instr;
    assign out_addr   = head_q.addr;
    assign out_err    = head_q.err;
    assign err_sticky = sticky_q;
    assign word_count = word_count_q;

    always_comb begin
        enc_word = base_instr;
        unique case (immSrc)
            2'b00: enc_word = base_instr | {imm[11:0], 20'b0};
            2'b01: enc_word = base_instr | {imm[11:5], 13'b0, imm[4:0], 7'b0};
            2'b10: enc_word = base_instr | {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            2'b11: enc_word = base_instr | {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            default: enc_word = base_instr;
        endcase
    end

`ifdef IMM_CHECK_EN
    always_comb begin
        imm_err = 1'b0;
        unique case (immSrc)
            2'b00, 2'b01: imm_err = (imm[31:11] != {21{imm[11]}});
            2'b10:        imm_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            2'b11:        imm_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            default:      imm_err = 1'b0;
        endcase
    end
`else
    assign imm_err = 1'b0;
`endif

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        sticky_d     = sticky_q;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = '{instr: enc_word, addr: addr_q, err: imm_err};
            wr_ptr_d        = ~wr_ptr_q;
            addr_d          = addr_q + 32'(ADDR_STEP);
            word_count_d    = word_count_q + 16'd1;
            sticky_d        = sticky_q | imm_err;
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
        // Output registers track the post-edge head; an empty FIFO keeps the last word.
        head_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
        if (clear) begin
            mem_d        = '0;
            head_d       = '0;
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            count_d      = 2'd0;
            addr_d       = BASE_ADDR;
            word_count_d = 16'd0;
            sticky_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q        <= '0;
            head_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            addr_q       <= BASE_ADDR;
            word_count_q <= 16'd0;
            sticky_q     <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            head_q       <= head_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            sticky_q     <= sticky_d;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed cases plus randomized traffic against a queue model.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] base_instr, imm, out_instr, out_addr;
    logic [1:0]  immSrc;
    logic        out_err, err_sticky;
    logic [15:0] word_count;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        last_head;
    logic [31:0] m_addr;
    logic [15:0] m_count;
    logic        m_sticky;

`ifdef IMM_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    imm_encoder dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .base_instr(base_instr), .imm(imm), .immSrc(immSrc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_sticky(err_sticky), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding written bit-by-bit from the field tables.
    function automatic logic [31:0] model_enc(logic [31:0] b, logic [31:0] v, logic [1:0] src);
        logic [31:0] w = b;
        case (src)
            2'd0: for (int i = 0; i < 12; i++) w[20+i] |= v[i];
            2'd1: begin
                for (int i = 0; i < 5; i++)  w[7+i]  |= v[i];
                for (int i = 5; i < 12; i++) w[20+i] |= v[i];
            end
            2'd2: begin
                w[31] |= v[12];
                w[7]  |= v[11];
                for (int i = 5; i < 11; i++) w[20+i] |= v[i];
                for (int i = 1; i < 5; i++)  w[7+i]  |= v[i];
            end
            default: begin
                w[31] |= v[20];
                w[20] |= v[11];
                for (int i = 1; i < 11; i++)  w[20+i] |= v[i];
                for (int i = 12; i < 20; i++) w[i]    |= v[i];
            end
        endcase
        return w;
    endfunction

    // Representability as a signed range plus alignment.
    function automatic logic model_err(logic [31:0] v, logic [1:0] src);
        longint s = longint'(signed'(v));
        if (!CHECK_ON) return 1'b0;
        case (src)
            2'd0, 2'd1: return (s < -2048 || s > 2047);
            2'd2:       return (s < -4096 || s > 4095 || v[0]);
            default:    return (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 1 || v[0]);
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        last_head = '{instr: 32'h0, addr: 32'h0, err: 1'b0};
        m_addr    = 32'h0;
        m_count   = 16'h0;
        m_sticky  = 1'b0;
    endtask

    // One cycle: drive at negedge, compare state-only outputs, update model at posedge.
    task automatic step(input logic rst, input logic clr, input logic iv,
                        input logic [31:0] b, input logic [31:0] v,
                        input logic [1:0] src, input logic ordy);
        bit do_push, do_pop;
        exp_t e;
        @(negedge clk);
        reset = rst; clear = clr; in_valid = iv; base_instr = b; imm = v;
        immSrc = src; out_ready = ordy;
        chk("in_ready",   32'(in_ready),   32'(q.size() != 2));
        chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
        chk("out_instr",  out_instr,       last_head.instr);
        chk("out_addr",   out_addr,        last_head.addr);
        chk("out_err",    32'(out_err),    32'(last_head.err));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("word_count", 32'(word_count), 32'(m_count));
        @(posedge clk);
        if (rst || clr) begin
            model_reset();
        end else begin
            do_push = iv && (q.size() != 2);
            do_pop  = ordy && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e = '{instr: model_enc(b, v, src), addr: m_addr, err: model_err(v, src)};
                q.push_back(e);
                m_addr   += 32'd4;
                m_count  += 16'd1;
                m_sticky |= e.err;
            end
            if (q.size() != 0) last_head = q[0];
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, ordy);
    endtask

    task automatic push(input logic [31:0] b, input logic [31:0] v,
                        input logic [1:0] src, input logic ordy);
        step(1'b0, 1'b0, 1'b1, b, v, src, ordy);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b1, 1'b1, 32'h13, 32'h5, 2'd0, 1'b1);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] bnd[8];
        bnd = '{32'h7FF, 32'hFFFF_F800, 32'h800, 32'hFFF, 32'h1000, 32'hFFFF_F000, 32'hF_FFFE, 32'h10_0000};
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return 32'($urandom_range(0, 4095)) - 32'd2048;
            2: return bnd[$urandom_range(0, 7)];
            3: return 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
            default: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'h1;
        endcase
    endfunction

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        base_instr = '0; imm = '0; immSrc = '0;
        model_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        idle(1'b0);

        // I-type, sign-extended -1
        push(32'h0000_0093, 32'hFFFF_FFFF, 2'd0, 1'b0);
        chk("i_instr", out_instr, 32'hFFF0_0093);
        chk("i_addr",  out_addr,  32'h0);
        chk("i_err",   32'(out_err), 32'h0);
        idle(1'b1);

        // S then B back-to-back
        do_clear();
        push(32'h0020_2023, 32'd8, 2'd1, 1'b1);
        chk("s_instr", out_instr, 32'h0020_2423);
        chk("s_addr",  out_addr,  32'h0);
        push(32'h0000_0063, 32'hFFFF_FFFC, 2'd2, 1'b1);
        chk("b_instr", out_instr, 32'hFE00_0EE3);
        chk("b_addr",  out_addr,  32'h4);
        chk("b_count", 32'(word_count), 32'd2);
        idle(1'b1);

        // J aligned and misaligned
        do_clear();
        push(32'h0000_00EF, 32'h800, 2'd3, 1'b1);
        chk("j_instr", out_instr, 32'h0010_00EF);
        chk("j_err",   32'(out_err), 32'h0);
        push(32'h0000_00EF, 32'h801, 2'd3, 1'b1);
        chk("j_odd_instr",  out_instr, 32'h0010_00EF);
        chk("j_odd_err",    32'(out_err), 32'(CHECK_ON));
        chk("j_odd_sticky", 32'(err_sticky), 32'(CHECK_ON));
        idle(1'b1);

        // I-type out of range
        push(32'h0000_0093, 32'h800, 2'd0, 1'b1);
        chk("i800_instr", out_instr, 32'h8000_0093);
        chk("i800_err",   32'(out_err), 32'(CHECK_ON));
        idle(1'b1);

        // Backpressure: third word waits until space frees
        do_clear();
        push(32'h13, 32'd1, 2'd0, 1'b0);
        push(32'h13, 32'd2, 2'd0, 1'b0);
        chk("bp_full", 32'(in_ready), 32'h0);
        push(32'h13, 32'd3, 2'd0, 1'b0);
        chk("bp_hold", out_instr, 32'h0010_0013);
        push(32'h13, 32'd3, 2'd0, 1'b1);
        chk("bp_addr1", out_addr, 32'h4);
        push(32'h13, 32'd3, 2'd0, 1'b1);
        idle(1'b1);
        chk("bp_addr2", out_addr, 32'h8);
        idle(1'b1);

        // Clear with two buffered (clear wins over a simultaneous push)
        push(32'h13, 32'h800, 2'd0, 1'b0);
        push(32'h13, 32'd7, 2'd0, 1'b0);
        do_clear();
        chk("clr_valid",  32'(out_valid), 32'h0);
        chk("clr_sticky", 32'(err_sticky), 32'h0);
        chk("clr_count",  32'(word_count), 32'h0);
        push(32'h13, 32'd9, 2'd0, 1'b0);
        chk("clr_addr", out_addr, 32'h0);

        // Mid-stream reset
        push(32'h13, 32'd4, 2'd1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h13, 32'd4, 2'd0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'b0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, rand_imm(), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) != 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
